// File: rtl/range_finder_pkg.sv
// rtl/range_finder_pkg.sv - shared types and constants for the range finder
// Contents: state_t (IDLE/COLLECT/ERROR), DEFAULT_WIDTH sample width.
// Optional feature macro used by the slice: RANGE_FINDER_VALID_EN.
package range_finder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ERROR   = 2'd2
    } state_t;

endpackage

// File: rtl/range_finder_if.sv
// rtl/range_finder_if.sv - sample/strobe/result bundle of the range finder
// Signals: data_in, go, finish (source -> finder); range, debug_error and,
// with RANGE_FINDER_VALID_EN defined, range_valid (finder -> reader).
// Modports: master = sample source / result reader, slave = range_finder.
interface range_finder_if
    import range_finder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] range;
    logic             debug_error;
`ifdef RANGE_FINDER_VALID_EN
    logic             range_valid;

    modport master (output data_in, go, finish, input range, debug_error, range_valid);
    modport slave  (input data_in, go, finish, output range, debug_error, range_valid);
`else
    modport master (output data_in, go, finish, input range, debug_error);
    modport slave  (input data_in, go, finish, output range, debug_error);
`endif

endinterface

// File: rtl/range_finder_bounds.sv
// rtl/range_finder_bounds.sv - running high/low bounds of the captured samples
// Ports: clock, reset (async active-low), data_in, init (load both bounds with
// data_in), update (fold data_in into bounds), next_max/next_min (combinational
// max(high,data_in) / min(low,data_in), used for the bound update and range).
module range_finder_bounds
    import range_finder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             init,
    input  logic             update,
    output logic [WIDTH-1:0] next_max,
    output logic [WIDTH-1:0] next_min
);

    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] low_q;

    assign next_max = (data_in > high_q) ? data_in : high_q;
    assign next_min = (data_in < low_q)  ? data_in : low_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            high_q <= '0;
            low_q  <= '1;
        end else if (init) begin
            high_q <= data_in;
            low_q  <= data_in;
        end else if (update) begin
            high_q <= next_max;
            low_q  <= next_min;
        end
    end

endmodule

// File: rtl/range_finder.sv
// rtl/range_finder.sv - streaming max-min detector between go and finish strobes
// Ports: clock, reset (async active-low), bus (range_finder_if.slave):
// data_in/go/finish in, range/debug_error out, range_valid out only when
// RANGE_FINDER_VALID_EN is defined.
module range_finder
    import range_finder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    range_finder_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    logic             init;
    logic             update;
    logic             load;
    logic [WIDTH-1:0] next_max;
    logic [WIDTH-1:0] next_min;
    logic [WIDTH-1:0] range_q;
    logic             error_q;

    range_finder_bounds #(.WIDTH(WIDTH)) u_bounds (
        .clock    (clock),
        .reset    (reset),
        .data_in  (bus.data_in),
        .init     (init),
        .update   (update),
        .next_max (next_max),
        .next_min (next_min)
    );

    always_comb begin
        next_state = state;
        init       = 1'b0;
        update     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.finish) begin
                    next_state = ERROR;
                end else if (bus.go) begin
                    next_state = COLLECT;
                    init       = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.go && bus.finish) begin
                    next_state = ERROR;
                end else if (bus.go) begin
                    init = 1'b1;
                end else if (bus.finish) begin
                    next_state = IDLE;
                    load       = 1'b1;
                end else begin
                    update = 1'b1;
                end
            end
            ERROR: begin
                if (bus.go && !bus.finish) begin
                    next_state = COLLECT;
                    init       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The finish sample is folded in through next_max/next_min, so the
    // difference can never underflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            range_q <= '0;
            error_q <= 1'b0;
        end else begin
            state   <= next_state;
            error_q <= (next_state == ERROR);
            if (load) begin
                range_q <= next_max - next_min;
            end
        end
    end

    assign bus.range       = range_q;
    assign bus.debug_error = error_q;

`ifdef RANGE_FINDER_VALID_EN
    logic valid_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= load;
        end
    end

    assign bus.range_valid = valid_q;
`endif

endmodule

// File: tb/tb_range_finder.sv
// tb/tb_range_finder.sv - directed and randomized bench for range_finder
module tb_range_finder;
    import range_finder_pkg::*;

    localparam int W = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    range_finder_if #(.WIDTH(W)) bus ();

    range_finder #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int valid_seen = 0;

    // reference: whether a sequence is open, error flag, samples of the open
    // sequence, and the last published range
    bit             m_open;
    bit             m_err;
    logic [W-1:0]   m_samples[$];
    logic [W-1:0]   m_range;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_open  = 1'b0;
        m_err   = 1'b0;
        m_range = '0;
        m_samples.delete();
    endtask

    function automatic logic [W-1:0] span();
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        mx = '0;
        mn = '1;
        foreach (m_samples[i]) begin
            if (m_samples[i] > mx) mx = m_samples[i];
            if (m_samples[i] < mn) mn = m_samples[i];
        end
        return mx - mn;
    endfunction

    task automatic step(input logic [W-1:0] d, input bit g, input bit f);
        bit exp_valid;
        bus.data_in = d;
        bus.go      = g;
        bus.finish  = f;
        @(posedge clock);
        #1;
        exp_valid = 1'b0;
        if (g && f) begin
            m_err  = 1'b1;
            m_open = 1'b0;
        end else if (g) begin
            m_err  = 1'b0;
            m_open = 1'b1;
            m_samples.delete();
            m_samples.push_back(d);
        end else if (f) begin
            if (m_open) begin
                m_samples.push_back(d);
                m_range   = span();
                m_open    = 1'b0;
                exp_valid = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_open) begin
            m_samples.push_back(d);
        end
        chk("range", bus.range, m_range);
        chk("debug_error", bus.debug_error, m_err);
`ifdef RANGE_FINDER_VALID_EN
        chk("range_valid", bus.range_valid, exp_valid);
        if (bus.range_valid) valid_seen++;
`else
        if (exp_valid) valid_seen++;
`endif
        bus.go     = 1'b0;
        bus.finish = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        chk("reset_range", bus.range, m_range);
        chk("reset_debug_error", bus.debug_error, 1'b0);
`ifdef RANGE_FINDER_VALID_EN
        chk("reset_range_valid", bus.range_valid, 1'b0);
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] d;
        int           r;
        bus.data_in = '0;
        bus.go      = 1'b0;
        bus.finish  = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_range", bus.range, 16'h0000);
        chk("reset_debug_error", bus.debug_error, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // 1: small spread around the sign boundary
        step(16'h7FFF, 1, 0);
        step(16'h8000, 0, 0);
        step(16'h8001, 0, 0);
        step(16'h7FFE, 0, 0);
        step(16'h7FFF, 0, 0);
        step(16'h7FFF, 0, 1);
        chk("s1_range", bus.range, 16'h0003);
        chk("s1_valid_count", valid_seen, 1);

        // 2: go and finish together from IDLE
        step(16'h1234, 1, 1);
        chk("s2_error", bus.debug_error, 1'b1);
        chk("s2_range_kept", bus.range, 16'h0003);

        // 3: finish held, then dropped, then go exits ERROR
        step(16'h0000, 0, 1);
        step(16'h0000, 0, 1);
        step(16'h0000, 0, 0);
        chk("s3_error_held", bus.debug_error, 1'b1);
        chk("s3_valid_count", valid_seen, 1);
        step(16'h0100, 1, 0);
        chk("s3_error_cleared", bus.debug_error, 1'b0);

        // 4: full span
        step(16'h0000, 0, 0);
        step(16'hFFFF, 0, 0);
        step(16'h0200, 0, 1);
        chk("s4_range", bus.range, 16'hFFFF);
        chk("s4_valid_count", valid_seen, 2);

        // two-sample sequence
        step(16'h0010, 1, 0);
        step(16'h0004, 0, 1);
        chk("two_sample_range", bus.range, 16'h000C);

        // 5: reset mid-collect, then a fresh sequence
        step(16'h0050, 1, 0);
        step(16'hF000, 0, 0);
        do_reset();
        step(16'h0005, 1, 0);
        step(16'h0009, 0, 0);
        step(16'h0007, 0, 1);
        chk("s5_fresh_range", bus.range, 16'h0004);

        // randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                default: d = W'($urandom);
            endcase
            if (i == 200) do_reset();
            if (r < 2)       step(d, 1, 1);
            else if (r < 10) step(d, 1, 0);
            else if (r < 18) step(d, 0, 1);
            else             step(d, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
